// File: rtl/cpu_run_ctrl.sv
// Run controller for single_cycle_cpu: sequences CPU reset, runs against a cycle budget,
// and stops the core on ebreak retire or timeout, reporting pass/fail from a0.
module cpu_run_ctrl #(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 4995,
    parameter int HALT_CYCLES = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ebreak,
    input  logic [31:0]      a0,
    output logic             cpu_rst,
    output logic             cpu_halt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {IDLE, RESET, RUN, HALT, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [15:0]      RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0]      HALT_LAST = 16'(HALT_CYCLES - 1);

    state_t           state, state_d;
    logic [15:0]      ph_cnt, ph_cnt_d;
    logic             cpu_rst_d, cpu_halt_d, busy_d, done_d, pass_d, timeout_d;
    logic [CNT_W-1:0] cycles_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ph_cnt   <= '0;
            cpu_rst  <= 1'b1;
            cpu_halt <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            cycles   <= '0;
        end else begin
            state    <= state_d;
            ph_cnt   <= ph_cnt_d;
            cpu_rst  <= cpu_rst_d;
            cpu_halt <= cpu_halt_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            timeout  <= timeout_d;
            cycles   <= cycles_d;
        end
    end

    always_comb begin
        state_d    = state;
        ph_cnt_d   = ph_cnt;
        cpu_rst_d  = cpu_rst;
        cpu_halt_d = cpu_halt;
        busy_d     = busy;
        done_d     = done;
        pass_d     = pass;
        timeout_d  = timeout;
        cycles_d   = cycles;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RESET;
                    ph_cnt_d   = '0;
                    cpu_rst_d  = 1'b1;
                    cpu_halt_d = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    cycles_d   = '0;
                end
            end
            RESET: begin
                if (ph_cnt == RST_LAST) begin
                    state_d   = RUN;
                    ph_cnt_d  = '0;
                    cpu_rst_d = 1'b0;
                end else begin
                    ph_cnt_d = ph_cnt + 16'd1;
                end
            end
            RUN: begin
                // The terminating cycle is counted, so the compare uses the pre-increment value
                if (cycles != '1) cycles_d = cycles + 1'b1;
                if (ebreak) begin
                    state_d    = HALT;
                    ph_cnt_d   = '0;
                    pass_d     = (a0 == 32'd0);
                    timeout_d  = 1'b0;
                    cpu_halt_d = 1'b1;
                end else if (cycles == MAX_LAST) begin
                    state_d    = HALT;
                    ph_cnt_d   = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b1;
                    cpu_halt_d = 1'b1;
                end
            end
            HALT: begin
                if (ph_cnt == HALT_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a scoreboard of expected run outcomes.
module tb_cpu_run_ctrl;

    localparam int MAXC = 20;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [31:0] cycles;
        int          term;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ebreak = 1'b0;
    logic [31:0] a0 = 32'd0;
    logic        cpu_rst, cpu_halt, busy, done, pass, timeout;
    logic [31:0] cycles;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    cpu_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(MAXC), .HALT_CYCLES(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ebreak(ebreak), .a0(a0),
        .cpu_rst(cpu_rst), .cpu_halt(cpu_halt), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
        chk({tag, "_cpu_halt"}, 32'(cpu_halt), 32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_pass"},     32'(pass),     32'd0);
        chk({tag, "_timeout"},  32'(timeout),  32'd0);
        chk({tag, "_cycles"},   cycles,        32'd0);
    endtask

    // Pulse start and walk through RESET; returns at the negedge of RUN cycle 1.
    task automatic start_run(input string tag);
        int rc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_rs_busy"},   32'(busy),     32'd1);
        chk({tag, "_rs_done"},   32'(done),     32'd0);
        chk({tag, "_rs_cycles"}, cycles,        32'd0);
        chk({tag, "_rs_halt"},   32'(cpu_halt), 32'd0);
        rc = 0;
        while (cpu_rst && rc < 10) begin
            rc++;
            @(negedge clk);
        end
        chk({tag, "_rst_len"}, 32'(rc), 32'd2);
    endtask

    // eb_at = RUN cycle carrying ebreak (0 = never).
    task automatic do_run(input string tag, input int eb_at, input logic [31:0] a0v);
        exp_t e, g;
        int term, dw;
        if (eb_at > 0 && eb_at <= MAXC) begin
            e.pass = (a0v == 32'd0); e.timeout = 1'b0; e.cycles = 32'(eb_at); e.term = eb_at;
        end else begin
            e.pass = 1'b0; e.timeout = 1'b1; e.cycles = 32'(MAXC); e.term = MAXC;
        end
        sb.push_back(e);
        start_run(tag);
        term = 0;
        for (int k = 1; k <= 50; k++) begin
            if (k == eb_at) begin
                ebreak = 1'b1;
                a0 = a0v;
            end
            @(negedge clk);
            ebreak = 1'b0;
            a0 = 32'hdead_beef;
            if (cpu_halt) begin
                term = k;
                break;
            end
        end
        chk({tag, "_halt_cycle"}, 32'(term), 32'(e.term));
        chk({tag, "_halt_busy"},  32'(busy),    32'd1);
        chk({tag, "_halt_rst"},   32'(cpu_rst), 32'd0);
        dw = 0;
        while (!done && dw < 10) begin
            dw++;
            @(negedge clk);
        end
        chk({tag, "_halt_len"}, 32'(dw), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            chk({tag, "_pass"},    32'(pass),    32'(g.pass));
            chk({tag, "_timeout"}, 32'(timeout), 32'(g.timeout));
            chk({tag, "_cycles"},  cycles,       g.cycles);
        end
        chk({tag, "_done_busy"}, 32'(busy),     32'd0);
        chk({tag, "_done_halt"}, 32'(cpu_halt), 32'd1);
        chk({tag, "_done_rst"},  32'(cpu_rst),  32'd0);
    endtask

    initial begin
        // Reset for two clocks, then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        chk("idle_eb_busy", 32'(busy), 32'd0);
        chk("idle_eb_done", 32'(done), 32'd0);

        do_run("eb_pass", 10, 32'd0);
        do_run("eb_fail", 10, 32'h3);

        // ebreak while in DONE must not disturb the held result
        ebreak = 1'b1;
        a0 = 32'd0;
        @(negedge clk);
        ebreak = 1'b0;
        chk("done_eb_pass",   32'(pass),  32'd0);
        chk("done_eb_cycles", cycles,     32'd10);
        chk("done_eb_done",   32'(done),  32'd1);

        do_run("timeout", 0, 32'd0);
        do_run("eb_last", MAXC, 32'd0);
        do_run("eb_first", 1, 32'd0);

        // Reset in the middle of RUN cycle 5
        start_run("midrst");
        repeat (4) @(negedge clk);
        chk("midrst_cycles_pre", cycles, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");

        do_run("rerun_idle", 7, 32'd0);
        do_run("rerun_done", 3, 32'h1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
